// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch codes, forward selects,
// and the multiplier FSM state type (used only when EXEC_MUL_EN is defined).
package exec_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SRL = 3'b110,
      ALU_MUL = 3'b111
   } alu_op_e;

   // Branch condition codes read the flag register {Z,V,N}.
   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_GE   = 2'b01;
   localparam logic [1:0] BR_LT   = 2'b10;
   localparam logic [1:0] BR_EQ   = 2'b11;

   localparam logic [1:0] FWD_REG     = 2'b00;
   localparam logic [1:0] FWD_WB      = 2'b01;
   localparam logic [1:0] FWD_MEM     = 2'b10;
   localparam logic [1:0] FWD_REG_ALT = 2'b11;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'b00,
      MUL_RUN  = 2'b01,
      MUL_DONE = 2'b10
   } mul_state_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage; returns the result and flags {Z,V,N}.
// ALU_MUL is not handled here and yields 0; the multiplier lives in the top.
module exec_alu
   import exec_pkg::*;
#(
   parameter int XLEN = 19
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      op,
   output logic [XLEN-1:0] result,
   output logic [2:0]      flags
);

   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] diff;
   logic            v_add;
   logic            v_sub;
   logic            v_out;

   always_comb begin
      sum   = a + b;
      diff  = a - b;
      // Signed overflow: operands agree (add) / differ (sub) and result sign flips.
      v_add = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      v_sub = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
      result = '0;
      v_out  = 1'b0;
      case (op)
         ALU_ADD: begin result = sum;  v_out = v_add; end
         ALU_SUB: begin result = diff; v_out = v_sub; end
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: begin
            result = {{(XLEN-1){1'b0}}, diff[XLEN-1] ^ v_sub};
            v_out  = v_sub;
         end
         ALU_SRL: result = a >> b;
         default: result = '0;
      endcase
      flags = {(result == '0), v_out, result[XLEN-1]};
   end

endmodule

// File: rtl/execute_stage_p.sv
// Pipeline execute stage: operand forwarding, ALU, branch resolution, EX/MEM register.
// Define EXEC_MUL_EN to add a multi-cycle shift-add multiplier on alu_ctrl_e = 111.
module execute_stage_p
   import exec_pkg::*;
#(
   parameter int XLEN  = 19,
   parameter int PC_W  = 15,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic             reg_write_e,
   input  logic             mem_write_e,
   input  logic             result_src_e,
   input  logic             jump_e,
   input  logic             alu_src_e,
   input  logic             byte_e,
   input  logic [1:0]       branch_e,
   input  logic [2:0]       alu_ctrl_e,
   input  logic [XLEN-1:0]  rd1_e,
   input  logic [XLEN-1:0]  rd2_e,
   input  logic [XLEN-1:0]  imm_e,
   input  logic [XLEN-1:0]  result_w,
   input  logic [PC_W-1:0]  pc_e,
   input  logic [REG_W-1:0] rd_e,
   input  logic [1:0]       fwd_a,
   input  logic [1:0]       fwd_b,
   output logic             pc_src_e,
   output logic [PC_W-1:0]  pc_target_e,
   output logic             busy_o,
   output logic             valid_m,
   output logic             reg_write_m,
   output logic             mem_write_m,
   output logic             result_src_m,
   output logic             byte_m,
   output logic [REG_W-1:0] rd_m,
   output logic [XLEN-1:0]  write_data_m,
   output logic [XLEN-1:0]  alu_result_m
);

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] fwd_b_val;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] ex_result;
   logic [2:0]      alu_flags;
   logic [2:0]      flags_q;
   logic            is_mul;
   logic            mul_done;
   logic            load;
   logic            flag_upd;
   logic            br_taken;

   always_comb begin
      case (fwd_a)
         FWD_WB:  src_a = result_w;
         FWD_MEM: src_a = alu_result_m;
         default: src_a = rd1_e;
      endcase
      case (fwd_b)
         FWD_WB:  fwd_b_val = result_w;
         FWD_MEM: fwd_b_val = alu_result_m;
         default: fwd_b_val = rd2_e;
      endcase
      src_b = alu_src_e ? imm_e : fwd_b_val;
   end

   exec_alu #(.XLEN(XLEN)) u_alu (
      .a      (src_a),
      .b      (src_b),
      .op     (alu_ctrl_e),
      .result (alu_res),
      .flags  (alu_flags)
   );

   assign is_mul = (alu_ctrl_e == ALU_MUL);

`ifdef EXEC_MUL_EN
   localparam int CW = $clog2(XLEN + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

   mul_state_e      mul_state;
   logic [CW-1:0]   mul_cnt;
   logic [XLEN-1:0] mul_acc;
   logic [XLEN-1:0] mul_mcand;
   logic [XLEN-1:0] mul_mplier;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_state  <= MUL_IDLE;
         mul_cnt    <= '0;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
      end else if (flush_i) begin
         mul_state <= MUL_IDLE;
         mul_cnt   <= '0;
      end else begin
         case (mul_state)
            MUL_IDLE: if (in_valid && is_mul) begin
               mul_state  <= MUL_RUN;
               mul_cnt    <= CNT_LAST;
               mul_acc    <= '0;
               mul_mcand  <= src_a;
               mul_mplier <= src_b;
            end
            MUL_RUN: begin
               // One multiplier bit per cycle; bits shifted past XLEN are dropped.
               if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
               mul_mcand  <= mul_mcand << 1;
               mul_mplier <= mul_mplier >> 1;
               if (mul_cnt == '0) mul_state <= MUL_DONE;
               else               mul_cnt   <= mul_cnt - 1'b1;
            end
            MUL_DONE: if (!stall_i) mul_state <= MUL_IDLE;
            default:  mul_state <= MUL_IDLE;
         endcase
      end
   end

   assign busy_o    = reset & (((mul_state == MUL_IDLE) & in_valid & is_mul) |
                               (mul_state == MUL_RUN));
   assign mul_done  = (mul_state == MUL_DONE);
   assign ex_result = mul_done ? mul_acc : alu_res;
`else
   assign busy_o    = 1'b0;
   assign mul_done  = 1'b0;
   assign ex_result = alu_res;
`endif

   // DONE captures the product even if upstream has already dropped in_valid.
   assign load     = (in_valid | mul_done) & ~busy_o & ~stall_i & ~flush_i;
   assign flag_upd = in_valid & ~busy_o & ~stall_i & ~flush_i & ~mul_done &
                     (branch_e == BR_NONE) & ~jump_e & ~is_mul;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        flags_q <= '0;
      else if (flag_upd) flags_q <= alu_flags;
   end

   always_comb begin
      case (branch_e)
         BR_EQ:   br_taken = flags_q[2];
         BR_GE:   br_taken = (flags_q[0] == flags_q[1]);
         BR_LT:   br_taken = (flags_q[0] != flags_q[1]);
         default: br_taken = 1'b0;
      endcase
      pc_src_e    = reset & in_valid & ~flush_i & (br_taken | jump_e);
      pc_target_e = pc_e + imm_e[PC_W-1:0];
   end

   // Stall holds EX/MEM; otherwise it takes either the instruction or a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_m      <= 1'b0;
         reg_write_m  <= 1'b0;
         mem_write_m  <= 1'b0;
         result_src_m <= 1'b0;
         byte_m       <= 1'b0;
         rd_m         <= '0;
         write_data_m <= '0;
         alu_result_m <= '0;
      end else if (flush_i || !stall_i) begin
         valid_m      <= load;
         reg_write_m  <= load & reg_write_e;
         mem_write_m  <= load & mem_write_e;
         result_src_m <= load & result_src_e;
         byte_m       <= load & byte_e;
         rd_m         <= load ? rd_e : '0;
         write_data_m <= load ? fwd_b_val : '0;
         alu_result_m <= load ? ex_result : '0;
      end
   end

endmodule

// File: tb/tb_execute_stage_p.sv
// Directed self-checking bench for execute_stage_p; covers the EXEC_MUL_EN build
// when that macro is defined and the op-111-disabled behaviour otherwise.
module tb_execute_stage_p;

   localparam int XLEN  = 19;
   localparam int PC_W  = 15;
   localparam int REG_W = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid, stall_i, flush_i;
   logic             reg_write_e, mem_write_e, result_src_e, jump_e, alu_src_e, byte_e;
   logic [1:0]       branch_e;
   logic [2:0]       alu_ctrl_e;
   logic [XLEN-1:0]  rd1_e, rd2_e, imm_e, result_w;
   logic [PC_W-1:0]  pc_e;
   logic [REG_W-1:0] rd_e;
   logic [1:0]       fwd_a, fwd_b;
   logic             pc_src_e, busy_o;
   logic [PC_W-1:0]  pc_target_e;
   logic             valid_m, reg_write_m, mem_write_m, result_src_m, byte_m;
   logic [REG_W-1:0] rd_m;
   logic [XLEN-1:0]  write_data_m, alu_result_m;

   int checks = 0;
   int failures = 0;

   execute_stage_p #(.XLEN(XLEN), .PC_W(PC_W), .REG_W(REG_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .stall_i(stall_i), .flush_i(flush_i),
      .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .result_src_e(result_src_e),
      .jump_e(jump_e), .alu_src_e(alu_src_e), .byte_e(byte_e), .branch_e(branch_e),
      .alu_ctrl_e(alu_ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
      .result_w(result_w), .pc_e(pc_e), .rd_e(rd_e), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .busy_o(busy_o), .valid_m(valid_m),
      .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
      .byte_m(byte_m), .rd_m(rd_m), .write_data_m(write_data_m), .alu_result_m(alu_result_m)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      in_valid = 0; stall_i = 0; flush_i = 0;
      reg_write_e = 0; mem_write_e = 0; result_src_e = 0; jump_e = 0; alu_src_e = 0; byte_e = 0;
      branch_e = 2'b00; alu_ctrl_e = 3'b000;
      rd1_e = '0; rd2_e = '0; imm_e = '0; result_w = '0;
      pc_e = '0; rd_e = '0; fwd_a = 2'b00; fwd_b = 2'b00;
   endtask

   task automatic alu_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      clear_inputs();
      in_valid = 1; reg_write_e = 1; alu_ctrl_e = op; rd1_e = a; rd2_e = b;
   endtask

   task automatic test_reset();
      clear_inputs();
      in_valid = 1; jump_e = 1; alu_ctrl_e = 3'b111; rd1_e = 19'd3; rd2_e = 19'd5;
      #2 reset = 0;
      #1;
      checks++; if (pc_src_e !== 1'b0) begin failures++; $display("FAIL reset_pc_src: got %b expected 0", pc_src_e); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
      step(); step();
      checks++; if (valid_m !== 1'b0) begin failures++; $display("FAIL reset_valid_m: got %b expected 0", valid_m); end
      checks++; if (alu_result_m !== '0) begin failures++; $display("FAIL reset_alu_result: got %h expected 0", alu_result_m); end
      checks++; if (reg_write_m !== 1'b0) begin failures++; $display("FAIL reset_reg_write: got %b expected 0", reg_write_m); end
      clear_inputs();
      @(negedge clk) reset = 1;
      step();
   endtask

   task automatic test_add_wrap();
      alu_op(3'b000, 19'h7FFFF, '0); alu_src_e = 1; imm_e = 19'd1; rd_e = 5'd3;
      step();
      checks++; if (alu_result_m !== 19'h00000) begin failures++; $display("FAIL add_wrap_result: got %h expected 00000", alu_result_m); end
      checks++; if (valid_m !== 1'b1) begin failures++; $display("FAIL add_wrap_valid: got %b expected 1", valid_m); end
      checks++; if (rd_m !== 5'd3 || reg_write_m !== 1'b1) begin failures++; $display("FAIL add_wrap_ctrl: got rd=%0d rw=%b expected rd=3 rw=1", rd_m, reg_write_m); end
      clear_inputs(); in_valid = 1; branch_e = 2'b11; #1;
      checks++; if (pc_src_e !== 1'b1) begin failures++; $display("FAIL add_wrap_zflag: got %b expected 1", pc_src_e); end
      // 0x3FFFF + 1 overflows: N=1, V=1
      alu_op(3'b000, 19'h3FFFF, 19'd1);
      step();
      checks++; if (alu_result_m !== 19'h40000) begin failures++; $display("FAIL add_ovf_result: got %h expected 40000", alu_result_m); end
      clear_inputs(); in_valid = 1; branch_e = 2'b01; #1;
      checks++; if (pc_src_e !== 1'b1) begin failures++; $display("FAIL br_ge_taken: got %b expected 1", pc_src_e); end
      branch_e = 2'b10; #1;
      checks++; if (pc_src_e !== 1'b0) begin failures++; $display("FAIL br_lt_not_taken: got %b expected 0", pc_src_e); end
      branch_e = 2'b11; #1;
      checks++; if (pc_src_e !== 1'b0) begin failures++; $display("FAIL br_eq_not_taken: got %b expected 0", pc_src_e); end
   endtask

   task automatic test_branch();
      alu_op(3'b001, 19'd5, 19'd5);
      step();
      checks++; if (alu_result_m !== '0) begin failures++; $display("FAIL sub_result: got %h expected 00000", alu_result_m); end
      clear_inputs(); in_valid = 1; branch_e = 2'b11; pc_e = 15'h0010; imm_e = 19'h00008; #1;
      checks++; if (pc_src_e !== 1'b1) begin failures++; $display("FAIL beq_taken: got %b expected 1", pc_src_e); end
      checks++; if (pc_target_e !== 15'h0018) begin failures++; $display("FAIL beq_target: got %h expected 0018", pc_target_e); end
      flush_i = 1; #1;
      checks++; if (pc_src_e !== 1'b0) begin failures++; $display("FAIL beq_flushed: got %b expected 0", pc_src_e); end
      // A branch carrying ADD 1+1 must not disturb Z
      flush_i = 0; alu_ctrl_e = 3'b000; rd1_e = 19'd1; rd2_e = 19'd1;
      step();
      checks++; if (pc_src_e !== 1'b1) begin failures++; $display("FAIL branch_keeps_flags: got %b expected 1", pc_src_e); end
      clear_inputs(); in_valid = 1; jump_e = 1; pc_e = 15'h7FF0; imm_e = 19'h00020; #1;
      checks++; if (pc_src_e !== 1'b1) begin failures++; $display("FAIL jump_taken: got %b expected 1", pc_src_e); end
      checks++; if (pc_target_e !== 15'h0010) begin failures++; $display("FAIL jump_target_wrap: got %h expected 0010", pc_target_e); end
      in_valid = 0; #1;
      checks++; if (pc_src_e !== 1'b0) begin failures++; $display("FAIL jump_invalid: got %b expected 0", pc_src_e); end
   endtask

   task automatic test_forward();
      alu_op(3'b000, 19'h00100, '0); alu_src_e = 1; imm_e = 19'h00023;
      step();
      checks++; if (alu_result_m !== 19'h00123) begin failures++; $display("FAIL fwd_setup: got %h expected 00123", alu_result_m); end
      alu_op(3'b000, 19'd0, 19'h00010); fwd_a = 2'b10;
      step();
      checks++; if (alu_result_m !== 19'h00133) begin failures++; $display("FAIL fwd_a_mem: got %h expected 00133", alu_result_m); end
      alu_op(3'b000, 19'd1, 19'h00999); alu_src_e = 1; imm_e = 19'd4; fwd_b = 2'b01;
      result_w = 19'h00055; mem_write_e = 1;
      step();
      checks++; if (alu_result_m !== 19'h00005) begin failures++; $display("FAIL fwd_imm_result: got %h expected 00005", alu_result_m); end
      checks++; if (write_data_m !== 19'h00055) begin failures++; $display("FAIL fwd_b_wb_data: got %h expected 00055", write_data_m); end
      checks++; if (mem_write_m !== 1'b1) begin failures++; $display("FAIL fwd_mem_write: got %b expected 1", mem_write_m); end
      alu_op(3'b011, 19'h000F0, 19'd0); fwd_a = 2'b11; fwd_b = 2'b10;
      step();
      checks++; if (alu_result_m !== 19'h000F5) begin failures++; $display("FAIL fwd_or: got %h expected 000F5", alu_result_m); end
      checks++; if (write_data_m !== 19'h00005) begin failures++; $display("FAIL fwd_b_mem_data: got %h expected 00005", write_data_m); end
      alu_op(3'b100, 19'h5A5A5, 19'h0FFFF);
      step();
      checks++; if (alu_result_m !== 19'h55A5A) begin failures++; $display("FAIL xor: got %h expected 55A5A", alu_result_m); end
      alu_op(3'b101, 19'h7FFFF, 19'd1);
      step();
      checks++; if (alu_result_m !== 19'h00001) begin failures++; $display("FAIL slt: got %h expected 00001", alu_result_m); end
      alu_op(3'b010, 19'h7FFFF, 19'h12345);
      step();
      checks++; if (alu_result_m !== 19'h12345) begin failures++; $display("FAIL and: got %h expected 12345", alu_result_m); end
   endtask

   task automatic test_stall_flush();
      alu_op(3'b000, 19'd1, 19'd2); rd_e = 5'd7;
      step();
      alu_op(3'b001, 19'h00050, 19'h00050); rd_e = 5'd2; stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (alu_result_m !== 19'd3 || valid_m !== 1'b1 || rd_m !== 5'd7)
            begin failures++; $display("FAIL stall_hold_%0d: got res=%h v=%b rd=%0d expected res=00003 v=1 rd=7", i, alu_result_m, valid_m, rd_m); end
      end
      flush_i = 1;
      step();
      checks++; if (valid_m !== 1'b0 || reg_write_m !== 1'b0) begin failures++; $display("FAIL flush_in_stall: got v=%b rw=%b expected 0 0", valid_m, reg_write_m); end
      clear_inputs(); in_valid = 1; branch_e = 2'b11; #1;
      checks++; if (pc_src_e !== 1'b0) begin failures++; $display("FAIL stall_keeps_flags: got %b expected 0", pc_src_e); end
      clear_inputs();
      step();
      checks++; if (valid_m !== 1'b0) begin failures++; $display("FAIL idle_bubble: got %b expected 0", valid_m); end
   endtask

`ifdef EXEC_MUL_EN
   task automatic run_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input string tag);
      int cnt = 0;
      logic bad = 1'b0;
      alu_op(3'b111, a, b); rd_e = 5'd9;
      #1;
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL %s_busy_start: got %b expected 1", tag, busy_o); end
      while (busy_o && cnt < 100) begin
         step();
         cnt++;
         if (valid_m !== 1'b0) bad = 1'b1;
      end
      checks++; if (cnt != 20) begin failures++; $display("FAIL %s_busy_cycles: got %0d expected 20", tag, cnt); end
      checks++; if (bad !== 1'b0) begin failures++; $display("FAIL %s_bubbles: got valid_m=1 expected 0 while busy", tag); end
   endtask

   task automatic test_mul();
      run_mul(19'd3, 19'd5, "mul3x5");
      step();
      checks++; if (alu_result_m !== 19'h0000F || valid_m !== 1'b1 || rd_m !== 5'd9)
         begin failures++; $display("FAIL mul3x5_result: got res=%h v=%b rd=%0d expected res=0000F v=1 rd=9", alu_result_m, valid_m, rd_m); end
      clear_inputs(); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mul_idle_after: got %b expected 0", busy_o); end
      run_mul(19'h7FFFF, 19'h7FFFF, "mulmax");
      stall_i = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (busy_o !== 1'b0 || valid_m !== 1'b0) begin failures++; $display("FAIL mul_done_stall_%0d: got busy=%b v=%b expected 0 0", i, busy_o, valid_m); end
      end
      stall_i = 0;
      step();
      checks++; if (alu_result_m !== 19'h00001 || valid_m !== 1'b1) begin failures++; $display("FAIL mulmax_result: got res=%h v=%b expected 00001 1", alu_result_m, valid_m); end
      clear_inputs();
   endtask

   task automatic test_mul_flush();
      alu_op(3'b111, 19'd3, 19'd5);
      repeat (5) step();
      checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL mul_flush_running: got %b expected 1", busy_o); end
      in_valid = 0; flush_i = 1;
      step();
      checks++; if (busy_o !== 1'b0 || valid_m !== 1'b0) begin failures++; $display("FAIL mul_flush: got busy=%b v=%b expected 0 0", busy_o, valid_m); end
      alu_op(3'b000, 19'd2, 19'd2); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL mul_flush_idle: got %b expected 0", busy_o); end
      step();
      checks++; if (alu_result_m !== 19'd4 || valid_m !== 1'b1) begin failures++; $display("FAIL mul_flush_next: got res=%h v=%b expected 00004 1", alu_result_m, valid_m); end
   endtask
`else
   task automatic test_op7_disabled();
      alu_op(3'b000, 19'd1, 19'd1);
      step();
      alu_op(3'b111, 19'd3, 19'd5); #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL op7_busy: got %b expected 0", busy_o); end
      step();
      checks++; if (alu_result_m !== '0 || valid_m !== 1'b1) begin failures++; $display("FAIL op7_result: got res=%h v=%b expected 00000 1", alu_result_m, valid_m); end
      clear_inputs(); in_valid = 1; branch_e = 2'b11; #1;
      checks++; if (pc_src_e !== 1'b0) begin failures++; $display("FAIL op7_keeps_flags: got %b expected 0", pc_src_e); end
   endtask
`endif

   task automatic test_async_reset();
      alu_op(3'b000, 19'd1, 19'd1);
      step();
      checks++; if (valid_m !== 1'b1 || alu_result_m !== 19'd2) begin failures++; $display("FAIL areset_setup: got v=%b res=%h expected 1 00002", valid_m, alu_result_m); end
      reset = 0;
      #2;
      checks++; if (valid_m !== 1'b0 || alu_result_m !== '0) begin failures++; $display("FAIL areset_clear: got v=%b res=%h expected 0 00000", valid_m, alu_result_m); end
      clear_inputs();
      @(negedge clk) reset = 1;
      step();
   endtask

   initial begin
      test_reset();
      test_add_wrap();
      test_branch();
      test_forward();
      test_stall_flush();
`ifdef EXEC_MUL_EN
      test_mul();
      test_mul_flush();
`else
      test_op7_disabled();
`endif
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/execute_stage_p.md
EXECUTE_STAGE_P -- requirements
Module: execute_stage_p

Interface
REQ-001 SHALL have parameter XLEN, default 19: datapath width.
REQ-002 SHALL have parameter PC_W, default 15: PC width, PC_W <= XLEN.
REQ-003 SHALL have parameter REG_W, default 5: register-index width.
REQ-004 SHALL have ports in this order:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- in_valid  in  1  instruction present
- stall_i  in  1  MEM stage hold
- flush_i  in  1  kill EX instruction
- reg_write_e, mem_write_e, result_src_e, jump_e, alu_src_e, byte_e  in  1 each  decoded controls
- branch_e  in  2  branch condition code
- alu_ctrl_e  in  3  ALU operation
- rd1_e, rd2_e, imm_e, result_w  in  XLEN  operands, immediate, WB forward value
- pc_e  in  PC_W  instruction PC
- rd_e  in  REG_W  destination
- fwd_a, fwd_b  in  2  forward selects
- pc_src_e  out  1  redirect taken
- pc_target_e  out  PC_W  redirect target
- busy_o  out  1  EX stall request upstream
- valid_m, reg_write_m, mem_write_m, result_src_m, byte_m  out  1 each  EX/MEM controls
- rd_m  out  REG_W
- write_data_m, alu_result_m  out  XLEN

Function
REQ-005 SHALL select SrcA/forwarded-B per fwd_x: 00 rdX_e, 01 result_w, 10 alu_result_m, 11 rdX_e.
REQ-006 SHALL use SrcB = imm_e when alu_src_e=1, else forwarded B; write_data_m SHALL capture forwarded B, never raw rd2_e.
REQ-007 SHALL compute pc_target_e = pc_e + imm_e[PC_W-1:0], modulo 2^PC_W.
REQ-008 SHALL hold flag register {Z,V,N}, updated from the ALU at an accepting edge only when in_valid, branch_e=00, jump_e=0, op not MUL.
REQ-009 SHALL drive pc_src_e combinationally, gated by in_valid and ~flush_i: branch_e 11 -> Z; 01 -> N==V; 10 -> N!=V; 00 -> 0; OR jump_e.
REQ-010 SHALL accept an instruction at an edge when in_valid, ~busy_o, ~stall_i.
REQ-011 SHALL, on accept, load EX/MEM with valid_m=1 and all controls, rd, write data, ALU result.
REQ-012 SHALL, when stall_i=1 and flush_i=0, hold all EX/MEM outputs unchanged.
REQ-013 SHALL, when busy_o=1 and stall_i=0, load a bubble (valid_m and all write controls 0).
REQ-014 SHALL, on flush_i=1, load a bubble and return the multiplier FSM to IDLE; flush_i overrides stall_i and busy_o.
REQ-015 SHALL wrap all ALU arithmetic modulo 2^XLEN; V per two's-complement add/sub rules.

Reset
REQ-016 SHALL, on reset low, clear EX/MEM outputs, flags and counter to 0 and force FSM IDLE, independent of clk.
REQ-017 SHALL drive busy_o=0 and pc_src_e=0 while reset is low.

Configuration
REQ-018 With EXEC_MUL_EN defined, alu_ctrl_e=111 SHALL be unsigned shift-add MUL producing the low XLEN bits of the product.
REQ-019 MUL FSM SHALL be IDLE -> RUN (operands latched, XLEN cycles, counter down to 0) -> DONE (1 cycle) -> IDLE.
REQ-020 busy_o SHALL be 1 in IDLE with a valid MUL presented and throughout RUN; 0 in DONE.
REQ-021 In DONE, with stall_i=0, EX/MEM SHALL capture the product; with stall_i=1, FSM SHALL remain in DONE.
REQ-022 Without EXEC_MUL_EN, alu_ctrl_e=111 SHALL produce result 0, no FSM SHALL be synthesised, and busy_o SHALL be tied to 0.

Structure
REQ-023 Package exec_pkg SHALL hold the ALU-op enum, branch-code constants, forward-select constants and the MUL FSM state enum.
REQ-024 ALU SHALL be sub-module exec_alu, combinational, parametrised by XLEN, outputs result and {Z,V,N}.

Verification
REQ-025 ADD rd1=0x7FFFF, imm=1, alu_src=1 -> alu_result_m=0x00000 one edge after accept, valid_m=1.
REQ-026 SUB 5-5 (branch_e=00), then branch_e=11, pc_e=0x0010, imm=0x0008 -> pc_src_e=1, pc_target_e=0x0018.
REQ-027 fwd_a=10 with alu_result_m=0x00123, rd1=0 -> forwarded SrcA=0x00123, result per op.
REQ-028 stall_i=1 for 3 cycles -> EX/MEM unchanged; flush_i=1 during stall -> valid_m=0 next edge.
REQ-029 EXEC_MUL_EN: MUL 0x00003 x 0x00005 -> busy_o high 20 cycles, alu_result_m=0x0000F at the DONE edge; bubbles before.
REQ-030 MUL with flush_i asserted mid-RUN -> FSM IDLE, busy_o=0, valid_m=0 next edge.
